// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel enable at half clk rate, horizontal/vertical
// counters and registered sync, display-area and frame-tick outputs.
module vga_sync_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pix_en,
   output logic [9:0] CounterX,
   output logic [8:0] CounterY,
   output logic       inDisplayArea,
   output logic       vga_h_sync,
   output logic       vga_v_sync,
   output logic       frame_tick
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
   localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
   localparam logic [9:0] V_LAST_VIS   = 10'(V_ACTIVE - 1);
   localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic       r_pix_en;
   logic [9:0] r_h_cnt;
   logic [9:0] r_v_cnt;
   logic [8:0] r_cnt_y;
   logic       r_de;
   logic       r_hs;
   logic       r_vs;
   logic       r_ft;

   logic       w_h_wrap;
   logic [9:0] w_h_next;
   logic [9:0] w_v_next;

   // Next counter values; outputs below are decoded from these so they line up with the counters.
   always_comb begin
      w_h_wrap = r_pix_en && (r_h_cnt == H_LAST);
      w_h_next = r_h_cnt;
      w_v_next = r_v_cnt;
      if (r_pix_en) begin
         w_h_next = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
      end
      if (w_h_wrap) begin
         w_v_next = (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pix_en <= 1'b0;
         r_h_cnt  <= 10'd0;
         r_v_cnt  <= 10'd0;
         r_cnt_y  <= 9'd0;
         r_de     <= 1'b0;
         r_hs     <= 1'b1;
         r_vs     <= 1'b1;
         r_ft     <= 1'b0;
      end else begin
         r_pix_en <= ~r_pix_en;
         r_h_cnt  <= w_h_next;
         r_v_cnt  <= w_v_next;
         r_cnt_y  <= (w_v_next < V_VIS) ? w_v_next[8:0] : 9'd0;
         r_de     <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
         r_hs     <= !((w_h_next >= H_SYNC_FIRST) && (w_h_next <= H_SYNC_LAST));
         r_vs     <= !((w_v_next >= V_SYNC_FIRST) && (w_v_next <= V_SYNC_LAST));
         // Pulses for the cycle following the step from the last visible line into blanking.
         r_ft     <= w_h_wrap && (r_v_cnt == V_LAST_VIS);
      end
   end

   assign pix_en        = r_pix_en;
   assign CounterX      = r_h_cnt;
   assign CounterY      = r_cnt_y;
   assign inDisplayArea = r_de;
   assign vga_h_sync    = r_hs;
   assign vga_v_sync    = r_vs;
   assign frame_tick    = r_ft;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: default-timing instance for line/reset checks and a
// shrunken-timing instance for frame, blanking and vertical-sync checks.
module tb_vga_sync_gen;

   typedef struct packed {
      logic       pe;
      logic [9:0] cx;
      logic [8:0] cy;
      logic       de;
      logic       hs;
      logic       vs;
      logic       ft;
   } obs_t;

   typedef struct {
      int   n;
      obs_t exp;
   } vec_t;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic rst_a, rst_b;
   logic pe_a, de_a, hs_a, vs_a, ft_a;
   logic pe_b, de_b, hs_b, vs_b, ft_b;
   logic [9:0] cx_a, cx_b;
   logic [8:0] cy_a, cy_b;
   obs_t oa, ob;

   vga_sync_gen dut_a (
      .clk(clk), .rst(rst_a), .pix_en(pe_a), .CounterX(cx_a), .CounterY(cy_a),
      .inDisplayArea(de_a), .vga_h_sync(hs_a), .vga_v_sync(vs_a), .frame_tick(ft_a)
   );

   vga_sync_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dut_b (
      .clk(clk), .rst(rst_b), .pix_en(pe_b), .CounterX(cx_b), .CounterY(cy_b),
      .inDisplayArea(de_b), .vga_h_sync(hs_b), .vga_v_sync(vs_b), .frame_tick(ft_b)
   );

   assign oa = {pe_a, cx_a, cy_a, de_a, hs_a, vs_a, ft_a};
   assign ob = {pe_b, cx_b, cy_b, de_b, hs_b, vs_b, ft_b};

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   function automatic obs_t mk(input int pe, input int cx, input int cy, input int de,
                               input int hs, input int vs, input int ft);
      obs_t o;
      o.pe = 1'(pe); o.cx = 10'(cx); o.cy = 9'(cy);
      o.de = 1'(de); o.hs = 1'(hs); o.vs = 1'(vs); o.ft = 1'(ft);
      return o;
   endfunction

   // Closed-form timing of the small instance, nb = edges since reset release.
   function automatic obs_t model_b(input int nb);
      int h, v;
      h = (nb / 2) % 24;
      v = (nb / 48) % 19;
      return mk(nb % 2, h, (v < 12) ? v : 0, (h < 16 && v < 12) ? 1 : 0,
                (h >= 18 && h <= 21) ? 0 : 1, (v >= 14 && v <= 15) ? 0 : 1,
                (nb >= 576 && ((nb - 576) % 912) == 0) ? 1 : 0);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at n=%0d: got %0d, expected %0d", name, cyc, act, exp);
   endtask

   task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at n=%0d: got pe=%0d cx=%0d cy=%0d de=%0d hs=%0d vs=%0d ft=%0d, expected pe=%0d cx=%0d cy=%0d de=%0d hs=%0d vs=%0d ft=%0d",
                    name, cyc, act.pe, act.cx, act.cy, act.de, act.hs, act.vs, act.ft,
                    exp.pe, exp.cx, exp.cy, exp.de, exp.hs, exp.vs, exp.ft);
   endtask

   // Per-cycle invariants on both instances.
   logic re_a, re_b;
   logic inv_on = 1'b0;
   obs_t prev [2];
   logic prev_re [2];
   logic prev_ok [2] = '{1'b0, 1'b0};

   always @(posedge clk) begin
      re_a <= rst_a;
      re_b <= rst_b;
   end

   task automatic inv(input int id, input obs_t cur, input logic re, input int htot, input int vact);
      logic ok;
      ok = 1'b1;
      if (cur.de && !(cur.hs && cur.vs)) ok = 1'b0;
      if (int'(cur.cx) >= htot) ok = 1'b0;
      if (int'(cur.cy) >= vact) ok = 1'b0;
      if (re) begin
         if (cur != mk(0, 0, 0, 0, 1, 1, 0)) ok = 1'b0;
      end else if (prev_ok[id]) begin
         if (cur.pe != !prev[id].pe) ok = 1'b0;
         if (!prev_re[id] && !prev[id].pe) begin
            if (cur.cx != prev[id].cx || cur.cy != prev[id].cy || cur.de != prev[id].de ||
                cur.hs != prev[id].hs || cur.vs != prev[id].vs || cur.ft) ok = 1'b0;
         end
      end
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL invariant_%0d at n=%0d: pe=%0d cx=%0d cy=%0d de=%0d hs=%0d vs=%0d ft=%0d rst=%0d",
                    id, cyc, cur.pe, cur.cx, cur.cy, cur.de, cur.hs, cur.vs, cur.ft, re);
      prev[id] = cur;
      prev_re[id] = re;
      prev_ok[id] = 1'b1;
   endtask

   always @(negedge clk) begin
      if (inv_on) begin
         inv(0, oa, re_a, 800, 480);
         inv(1, ob, re_b, 24, 12);
      end
   end

   initial begin
      vec_t vecs [13];
      int hs_low, hs_first, de_hi, vs_low, vs_first, ft_cnt, nb;
      int ft_pos [4];
      obs_t rst_obs;

      vecs[0]  = '{1,    mk(1, 0,   0, 1, 1, 1, 0)};
      vecs[1]  = '{2,    mk(0, 1,   0, 1, 1, 1, 0)};
      vecs[2]  = '{4,    mk(0, 2,   0, 1, 1, 1, 0)};
      vecs[3]  = '{1279, mk(1, 639, 0, 1, 1, 1, 0)};
      vecs[4]  = '{1280, mk(0, 640, 0, 0, 1, 1, 0)};
      vecs[5]  = '{1311, mk(1, 655, 0, 0, 1, 1, 0)};
      vecs[6]  = '{1312, mk(0, 656, 0, 0, 0, 1, 0)};
      vecs[7]  = '{1503, mk(1, 751, 0, 0, 0, 1, 0)};
      vecs[8]  = '{1504, mk(0, 752, 0, 0, 1, 1, 0)};
      vecs[9]  = '{1599, mk(1, 799, 0, 0, 1, 1, 0)};
      vecs[10] = '{1600, mk(0, 0,   1, 1, 1, 1, 0)};
      vecs[11] = '{1601, mk(1, 0,   1, 1, 1, 1, 0)};
      vecs[12] = '{3200, mk(0, 0,   2, 1, 1, 1, 0)};

      rst_obs = mk(0, 0, 0, 0, 1, 1, 0);
      hs_low = 0; hs_first = -1; de_hi = 0; vs_low = 0; vs_first = -1; ft_cnt = 0;
      for (int i = 0; i < 4; i++) ft_pos[i] = -1;

      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (4) @(negedge clk);
      chk_obs("reset_a", oa, rst_obs);
      chk_obs("reset_b", ob, rst_obs);
      inv_on = 1'b1;
      rst_a = 1'b0;
      rst_b = 1'b0;

      for (int n = 1; n <= 4700; n++) begin
         @(negedge clk);
         cyc = n;

         for (int k = 0; k < 13; k++)
            if (vecs[k].n == n) chk_obs("vec_a", oa, vecs[k].exp);

         if (n >= 1600 && n <= 3199) begin
            if (!oa.hs) begin
               hs_low++;
               if (hs_first < 0) hs_first = n;
            end
            if (oa.de) de_hi++;
         end

         if (n == 4600) begin
            chk("a_hs_before_rst", int'(oa.hs), 0);
            rst_a = 1'b1;
         end
         if (n == 4601) begin
            chk_obs("a_mid_rst", oa, rst_obs);
            rst_a = 1'b0;
         end
         if (n == 4602) chk_obs("a_rel_e1", oa, mk(1, 0, 0, 1, 1, 1, 0));
         if (n == 4603) chk_obs("a_rel_e2", oa, mk(0, 1, 0, 1, 1, 1, 0));
         if (n == 4605) chk_obs("a_rel_e4", oa, mk(0, 2, 0, 1, 1, 1, 0));

         if (n != 2535) begin
            nb = (n <= 2534) ? n : n - 2535;
            chk_obs("model_b", ob, model_b(nb));
         end
         if (n <= 2534) begin
            if (ob.ft) begin
               if (ft_cnt < 4) ft_pos[ft_cnt] = n;
               ft_cnt++;
            end
            if (n <= 912 && !ob.vs) begin
               vs_low++;
               if (vs_first < 0) vs_first = n;
            end
         end
         if (n == 271) chk("b_de_before_blank", int'(ob.de), 1);
         if (n == 272) begin
            chk("b_de_at_blank", int'(ob.de), 0);
            chk("b_cy_at_blank", int'(ob.cy), 5);
         end
         if (n == 287) chk("b_cy_end_line", int'(ob.cy), 5);
         if (n == 2534) begin
            chk("b_vs_before_rst", int'(ob.vs), 0);
            chk("b_hs_before_rst", int'(ob.hs), 0);
            rst_b = 1'b1;
         end
         if (n == 2535) begin
            chk_obs("b_mid_rst", ob, rst_obs);
            rst_b = 1'b0;
         end
      end

      chk("a_hs_low_clk", hs_low, 192);
      chk("a_hs_offset", hs_first - 1600, 1312);
      chk("a_de_high_clk", de_hi, 1280);
      chk("b_vs_low_clk", vs_low, 96);
      chk("b_vs_first", vs_first, 672);
      chk("b_ft_count", ft_cnt, 3);
      chk("b_ft_first", ft_pos[0], 576);
      chk("b_ft_period0", ft_pos[1] - ft_pos[0], 912);
      chk("b_ft_period1", ft_pos[2] - ft_pos[1], 912);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
